// File: rtl/warp_register_block.sv
// Per-warp GPR file for an 8-lane SIMT core: one lane-masked write port, two lane-masked combinational read ports.
// Optional same-cycle write-through forwarding is enabled by defining WRITE_BYPASS_EN.

module warp_rf_lane #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_REGS   = 16,
  parameter int NUM_WARPS  = 16,
  parameter int ADDR_W     = 4,
  parameter int WARP_W     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WARP_W-1:0]     warp_sel,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re_0,
  input  logic [ADDR_W-1:0]     raddr_0,
  input  logic                  re_1,
  input  logic [ADDR_W-1:0]     raddr_1,
  output logic [DATA_WIDTH-1:0] rdata_0,
  output logic [DATA_WIDTH-1:0] rdata_1
);
  localparam int DEPTH = NUM_WARPS * NUM_REGS;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [DATA_WIDTH-1:0] rd_0, rd_1;

  // Flat index {warp, reg}; NUM_REGS is a power of two so concatenation is exact.
  logic [WARP_W+ADDR_W-1:0] widx, ridx_0, ridx_1;
  assign widx   = {warp_sel, waddr};
  assign ridx_0 = {warp_sel, raddr_0};
  assign ridx_1 = {warp_sel, raddr_1};

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[widx] = wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  always_comb begin
    rd_0 = mem_q[ridx_0];
    rd_1 = mem_q[ridx_1];
`ifdef WRITE_BYPASS_EN
    if (we && (raddr_0 == waddr)) rd_0 = wdata;
    if (we && (raddr_1 == waddr)) rd_1 = wdata;
`endif
    rdata_0 = re_0 ? rd_0 : '0;
    rdata_1 = re_1 ? rd_1 : '0;
  end
endmodule

module warp_register_block #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_REGS   = 16,
  parameter int NUM_WARPS  = 16,
  parameter int ADDR_W     = 4,
  parameter int WARP_W     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WARP_W-1:0]     warp_selector,
  input  logic [7:0]            write_en,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata_0,
  input  logic [DATA_WIDTH-1:0] wdata_1,
  input  logic [DATA_WIDTH-1:0] wdata_2,
  input  logic [DATA_WIDTH-1:0] wdata_3,
  input  logic [DATA_WIDTH-1:0] wdata_4,
  input  logic [DATA_WIDTH-1:0] wdata_5,
  input  logic [DATA_WIDTH-1:0] wdata_6,
  input  logic [DATA_WIDTH-1:0] wdata_7,
  input  logic [7:0]            read_en_0,
  input  logic [ADDR_W-1:0]     raddr_0,
  input  logic [7:0]            read_en_1,
  input  logic [ADDR_W-1:0]     raddr_1,
  output logic [DATA_WIDTH-1:0] rdata_0_0,
  output logic [DATA_WIDTH-1:0] rdata_0_1,
  output logic [DATA_WIDTH-1:0] rdata_0_2,
  output logic [DATA_WIDTH-1:0] rdata_0_3,
  output logic [DATA_WIDTH-1:0] rdata_0_4,
  output logic [DATA_WIDTH-1:0] rdata_0_5,
  output logic [DATA_WIDTH-1:0] rdata_0_6,
  output logic [DATA_WIDTH-1:0] rdata_0_7,
  output logic [DATA_WIDTH-1:0] rdata_1_0,
  output logic [DATA_WIDTH-1:0] rdata_1_1,
  output logic [DATA_WIDTH-1:0] rdata_1_2,
  output logic [DATA_WIDTH-1:0] rdata_1_3,
  output logic [DATA_WIDTH-1:0] rdata_1_4,
  output logic [DATA_WIDTH-1:0] rdata_1_5,
  output logic [DATA_WIDTH-1:0] rdata_1_6,
  output logic [DATA_WIDTH-1:0] rdata_1_7
);
  localparam int NUM_LANES = 8;

  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] wdata_l, rdata_0_l, rdata_1_l;

  assign wdata_l = {wdata_7, wdata_6, wdata_5, wdata_4, wdata_3, wdata_2, wdata_1, wdata_0};

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    warp_rf_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_REGS   (NUM_REGS),
      .NUM_WARPS  (NUM_WARPS),
      .ADDR_W     (ADDR_W),
      .WARP_W     (WARP_W)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .warp_sel (warp_selector),
      .we       (write_en[l]),
      .waddr    (waddr),
      .wdata    (wdata_l[l]),
      .re_0     (read_en_0[l]),
      .raddr_0  (raddr_0),
      .re_1     (read_en_1[l]),
      .raddr_1  (raddr_1),
      .rdata_0  (rdata_0_l[l]),
      .rdata_1  (rdata_1_l[l])
    );
  end

  assign {rdata_0_7, rdata_0_6, rdata_0_5, rdata_0_4,
          rdata_0_3, rdata_0_2, rdata_0_1, rdata_0_0} = rdata_0_l;
  assign {rdata_1_7, rdata_1_6, rdata_1_5, rdata_1_4,
          rdata_1_3, rdata_1_2, rdata_1_1, rdata_1_0} = rdata_1_l;
endmodule

// File: tb/tb_warp_register_block.sv
// Bench for warp_register_block: directed vector table, collision sequence, and randomized traffic
// checked against an array-based model of the register file.

module tb_warp_register_block;
  typedef logic [7:0][63:0] lanes_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] ws;
  logic [7:0] we;
  logic [3:0] waddr;
  lanes_t     wd;
  logic [7:0] re0, re1;
  logic [3:0] ra0, ra1;
  logic [63:0] r0_0, r0_1, r0_2, r0_3, r0_4, r0_5, r0_6, r0_7;
  logic [63:0] r1_0, r1_1, r1_2, r1_3, r1_4, r1_5, r1_6, r1_7;
  lanes_t     rd0, rd1;

  assign rd0 = {r0_7, r0_6, r0_5, r0_4, r0_3, r0_2, r0_1, r0_0};
  assign rd1 = {r1_7, r1_6, r1_5, r1_4, r1_3, r1_2, r1_1, r1_0};

  always #5 clk = ~clk;

  warp_register_block dut (
    .clk(clk), .rst(rst), .warp_selector(ws), .write_en(we), .waddr(waddr),
    .wdata_0(wd[0]), .wdata_1(wd[1]), .wdata_2(wd[2]), .wdata_3(wd[3]),
    .wdata_4(wd[4]), .wdata_5(wd[5]), .wdata_6(wd[6]), .wdata_7(wd[7]),
    .read_en_0(re0), .raddr_0(ra0), .read_en_1(re1), .raddr_1(ra1),
    .rdata_0_0(r0_0), .rdata_0_1(r0_1), .rdata_0_2(r0_2), .rdata_0_3(r0_3),
    .rdata_0_4(r0_4), .rdata_0_5(r0_5), .rdata_0_6(r0_6), .rdata_0_7(r0_7),
    .rdata_1_0(r1_0), .rdata_1_1(r1_1), .rdata_1_2(r1_2), .rdata_1_3(r1_3),
    .rdata_1_4(r1_4), .rdata_1_5(r1_5), .rdata_1_6(r1_6), .rdata_1_7(r1_7)
  );

  int checks = 0;
  int failures = 0;

  // Reference storage indexed [lane][warp][reg]
  logic [63:0] ref_mem [8][16][16];

  function automatic lanes_t mk(input logic [63:0] v, input logic [7:0] m);
    lanes_t r;
    for (int l = 0; l < 8; l++) r[l] = m[l] ? v : 64'h0;
    return r;
  endfunction

  function automatic lanes_t model_read(input logic [7:0] re, input logic [3:0] ra);
    lanes_t r;
    for (int l = 0; l < 8; l++) begin
      r[l] = 64'h0;
      if (re[l]) begin
        r[l] = ref_mem[l][ws][ra];
`ifdef WRITE_BYPASS_EN
        if (we[l] && ra == waddr) r[l] = wd[l];
`endif
      end
    end
    return r;
  endfunction

  task automatic check(input string name, input lanes_t got, input lanes_t exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic check_model(input string name);
    check({name, "_p0"}, rd0, model_read(re0, ra0));
    check({name, "_p1"}, rd1, model_read(re1, ra1));
  endtask

  // One rising edge; the model absorbs the same inputs the DUT sampled.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int l = 0; l < 8; l++)
        for (int w = 0; w < 16; w++)
          for (int r = 0; r < 16; r++) ref_mem[l][w][r] = 64'h0;
    end else begin
      for (int l = 0; l < 8; l++) if (we[l]) ref_mem[l][ws][waddr] = wd[l];
    end
    #1;
  endtask

  task automatic idle();
    rst = 0; we = 0; re0 = 0; re1 = 0; ra0 = 0; ra1 = 0; waddr = 0; wd = '0;
  endtask

  typedef struct {
    string      name;
    logic       rst;
    logic [3:0] ws;
    logic [7:0] we;
    logic [3:0] waddr;
    logic [63:0] wdata;
    logic [7:0] re0;
    logic [3:0] ra0;
    logic [7:0] re1;
    logic [3:0] ra1;
    lanes_t     exp0;
    lanes_t     exp1;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #200_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{"reset_wins", 1, 4'd0, 8'hFF, 4'd3, 64'h1234, 8'hFF, 4'd0, 8'hFF, 4'd3, mk(0, 0), mk(0, 0)};
    vecs[1] = '{"wr_w3_r5",   0, 4'd3, 8'hFF, 4'd5, 64'hA5A5, 8'hFF, 4'd5, 8'h00, 4'd5, mk(64'hA5A5, 8'hFF), mk(0, 0)};
    vecs[2] = '{"wr_w4_r5",   0, 4'd4, 8'hFF, 4'd5, 64'h5A5A, 8'hFF, 4'd5, 8'hFF, 4'd5, mk(64'h5A5A, 8'hFF), mk(64'h5A5A, 8'hFF)};
    vecs[3] = '{"iso_w3_mask",0, 4'd3, 8'h00, 4'd0, 64'h0,    8'hFF, 4'd5, 8'h0F, 4'd5, mk(64'hA5A5, 8'hFF), mk(64'hA5A5, 8'h0F)};
    vecs[4] = '{"lane0_only", 0, 4'd3, 8'h01, 4'd5, 64'hDEAD, 8'hFF, 4'd5, 8'hF0, 4'd5,
                mk(64'hA5A5, 8'hFE) | mk(64'hDEAD, 8'h01), mk(64'hA5A5, 8'hF0)};
    vecs[5] = '{"wr_r2",      0, 4'd0, 8'hFF, 4'd2, 64'h1111, 8'hFF, 4'd2, 8'h00, 4'd0, mk(64'h1111, 8'hFF), mk(0, 0)};
    vecs[6] = '{"wr_r9_dual", 0, 4'd0, 8'hFF, 4'd9, 64'h2222, 8'hFF, 4'd2, 8'hFF, 4'd9, mk(64'h1111, 8'hFF), mk(64'h2222, 8'hFF)};
    vecs[7] = '{"dual_mask",  0, 4'd0, 8'h00, 4'd0, 64'h0,    8'h0F, 4'd9, 8'hFF, 4'd2, mk(64'h2222, 8'h0F), mk(64'h1111, 8'hFF)};

    idle(); ws = 0;
    rst = 1; tick(); rst = 0;

    // Every register of every warp reads zero after reset
    re0 = 8'hFF; re1 = 8'hFF;
    for (int w = 0; w < 16; w++)
      for (int r = 0; r < 16; r++) begin
        ws = w[3:0]; ra0 = r[3:0]; ra1 = 4'(15 - r); #1;
        check("reset_zero_p0", rd0, '0);
        check("reset_zero_p1", rd1, '0);
      end

    // Directed table: apply, clock, compare post-edge outputs
    for (int i = 0; i < 8; i++) begin
      rst = vecs[i].rst; ws = vecs[i].ws; we = vecs[i].we; waddr = vecs[i].waddr;
      for (int l = 0; l < 8; l++) wd[l] = vecs[i].wdata;
      re0 = vecs[i].re0; ra0 = vecs[i].ra0; re1 = vecs[i].re1; ra1 = vecs[i].ra1;
      tick();
      check({vecs[i].name, "_p0"}, rd0, vecs[i].exp0);
      check({vecs[i].name, "_p1"}, rd1, vecs[i].exp1);
    end
    idle();

    // Same-cycle collision on warp 1 reg 7
    ws = 1; we = 8'hFF; waddr = 7;
    for (int l = 0; l < 8; l++) wd[l] = 64'hCAFE;
    tick();
    for (int l = 0; l < 8; l++) wd[l] = 64'hBEEF;
    re0 = 8'hFF; ra0 = 7; #1;
`ifdef WRITE_BYPASS_EN
    check("collide_pre", rd0, mk(64'hBEEF, 8'hFF));
`else
    check("collide_pre", rd0, mk(64'hCAFE, 8'hFF));
`endif
    tick();
    we = 0; #1;
    check("collide_post", rd0, mk(64'hBEEF, 8'hFF));
    idle();

    // Full sweep: write all lanes, read back on port 0, port 1, then both
    rst = 1; tick(); rst = 0;
    for (int w = 0; w < 16; w++)
      for (int r = 0; r < 16; r++)
        for (int k = 0; k < 10; k++) begin
          ws = w[3:0]; waddr = r[3:0]; we = 8'hFF;
          for (int l = 0; l < 8; l++) wd[l] = {$urandom, $urandom};
          re0 = 0; re1 = 0;
          tick();
          we = 0; re0 = 8'hFF; ra0 = r[3:0]; #1;
          check_model("sweep_p0");
          re0 = 0; re1 = 8'hFF; ra1 = r[3:0]; #1;
          check_model("sweep_p1");
          re0 = 8'hFF; #1;
          check_model("sweep_both");
          check("sweep_both_eq", rd0, rd1);
        end
    idle();

    // Random traffic, checked before and after each edge
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      ws = 4'($urandom); we = 8'($urandom); waddr = 4'($urandom);
      for (int l = 0; l < 8; l++) wd[l] = {$urandom, $urandom};
      re0 = 8'($urandom); re1 = 8'($urandom);
      ra0 = ($urandom_range(0, 3) == 0) ? waddr : 4'($urandom);
      ra1 = ($urandom_range(0, 3) == 0) ? ra0 : 4'($urandom);
      #1;
      check_model("rand_pre");
      tick();
      check_model("rand_post");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/warp_register_block.md
Name: warp_register_block

Overview:
Per-warp general-purpose register file for an 8-lane SIMT core. It holds NUM_WARPS x NUM_REGS registers of DATA_WIDTH bits per lane. It has one lane-masked synchronous write port and two lane-masked combinational read ports. Sits between the issue/operand-fetch stage and the lane ALUs; warp_selector picks the active warp's bank for both reads and writes.

Parameters:
DATA_WIDTH, 64, register width per lane
NUM_REGS, 16, registers per warp per lane
NUM_WARPS, 16, warp banks
ADDR_W, 4, register address width; equals clog2(NUM_REGS)
WARP_W, 4, warp selector width; equals clog2(NUM_WARPS)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous active-high reset
warp_selector  in  WARP_W  warp bank used by the write port and both read ports
write_en  in  8  per-lane write enable; bit L enables lane L
waddr  in  ADDR_W  write register address, shared by all lanes
wdata_0 .. wdata_7  in  DATA_WIDTH each  write data for lanes 0..7
read_en_0  in  8  per-lane enable, read port 0
raddr_0  in  ADDR_W  read address, port 0, shared by all lanes
read_en_1  in  8  per-lane enable, read port 1
raddr_1  in  ADDR_W  read address, port 1
rdata_0_0 .. rdata_0_7  out  DATA_WIDTH each  port 0 data, lanes 0..7
rdata_1_0 .. rdata_1_7  out  DATA_WIDTH each  port 1 data, lanes 0..7

Behaviour:
- Storage: mem[lane][warp][reg], 8 x NUM_WARPS x NUM_REGS entries of DATA_WIDTH bits.
- Reset: rst high at a rising edge clears every entry to 0. Outputs are combinational, so they read 0 after reset. Reset wins over a write in the same cycle.
- Write: at a rising edge with rst low, for each lane L with write_en[L]=1: mem[L][warp_selector][waddr] <= wdata_L. Lanes with write_en[L]=0 are unchanged. Writes are never disturbed by read activity.
- Read (port P in {0,1}, lane L): combinational, zero cycles of latency. rdata_P_L = mem[L][warp_selector][raddr_P] when read_en_P[L]=1, else 0.
- Both ports are fully independent. They may read the same or different addresses in the same cycle, and both return identical data when the addresses match.
- Read-after-write: a value written at edge N is visible on the read ports immediately after edge N.
- Same-cycle read of the address being written: returns the old value, with no bypass (unless WRITE_BYPASS_EN is defined).
- warp_selector, raddr_* and read_en_* may change at any time; outputs follow combinationally.
- Address and selector fields are full-range, so there are no out-of-range cases. All 16 registers x 16 warps are addressable.
- Banks are isolated: a write to warp W never alters warp W' != W. A write to lane L never alters other lanes.

Optional Feature:
WRITE_BYPASS_EN
- Defined: when write_en[L]=1 and the read port's raddr_P equals waddr (same warp_selector), with read_en_P[L]=1, rdata_P_L returns wdata_L combinationally in the write cycle. This is write-through forwarding.
- Undefined: no forwarding; same-cycle reads return the stored (old) value.
- Storage behaviour is identical in both builds.

Test Plan:
- Reset: assert rst for 1 edge, then enable all reads on every reg/warp -> all rdata = 0.
- Full sweep: for warp 0..15, reg 0..15, repeat 10x: write_en=8'hFF with random wdata_0..7, one edge, then read_en_0=8'hFF with raddr_0=waddr -> rdata_0_L == wdata_L. Next cycle, read port 1 alone -> rdata_1_L == wdata_L. Next cycle, both ports on the same address -> both match.
- Read enable masking: read_en_0=8'h0F -> lanes 0..3 carry data, rdata_0_4..7 = 0. write_en=8'h01 with wdata_1=64'hDEAD -> lane 1 unchanged.
- Warp isolation: write 64'hA5A5 to warp 3 reg 5, then 64'h5A5A to warp 4 reg 5 -> reading warp 3 reg 5 still returns 64'hA5A5.
- Dual-port distinct addresses: reg2=64'h1111, reg9=64'h2222; raddr_0=2, raddr_1=9 in the same cycle -> 64'h1111 on port 0, 64'h2222 on port 1.
- Same-cycle collision: write 64'hBEEF to reg 7 holding 64'hCAFE while reading reg 7 -> 64'hCAFE before the edge (64'hBEEF with WRITE_BYPASS_EN), and 64'hBEEF after the edge.
